// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/EXEC/HALT FSM over a req/ready fetch port.
// Define MULTICYCLE_CORE_BRANCH_EN to add beq/bne.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halt,
  output logic        illegal,
  output logic [31:0] halt_code
);
  localparam int          AW     = $clog2(NREGS);
  localparam logic [31:0] NR     = NREGS;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [6:0]  OP_LUI = 7'b0110111;
  localparam logic [6:0]  OP_AUI = 7'b0010111;
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_REG = 7'b0110011;
  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [6:0]  OP_JLR = 7'b1100111;
`ifdef MULTICYCLE_CORE_BRANCH_EN
  localparam logic [6:0]  OP_BR  = 7'b1100011;
`endif

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] halt_code_q;
  logic        halt_q;
  logic        illegal_q;
  logic [31:0] rf_q [NREGS];

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;

  assign opc   = ir_q[6:0];
  assign rd    = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign rs1   = ir_q[19:15];
  assign rs2   = ir_q[24:20];
  assign f7    = ir_q[31:25];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                  ir_q[20], ir_q[30:21], 1'b0};
`ifdef MULTICYCLE_CORE_BRANCH_EN
  logic [31:0] imm_b;
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                  ir_q[30:25], ir_q[11:8], 1'b0};
`endif

  assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[AW-1:0]];
  assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[AW-1:0]];

  function automatic logic idx_bad(input logic [4:0] r);
    return {27'b0, r} >= NR;
  endfunction

  logic        legal;
  logic        brk;
  logic        jump;
  logic        use_rd;
  logic        use_r1;
  logic        use_r2;
  logic [31:0] wdata;
  logic [31:0] npc;
  logic        halt_now;

  always_comb begin
    legal  = 1'b0;
    brk    = 1'b0;
    jump   = 1'b0;
    use_rd = 1'b0;
    use_r1 = 1'b0;
    use_r2 = 1'b0;
    wdata  = 32'd0;
    npc    = pc_q + 32'd4;
    unique case (1'b1)
      (ir_q == EBREAK): brk = 1'b1;
      (opc == OP_LUI): begin
        legal  = 1'b1;
        use_rd = 1'b1;
        wdata  = imm_u;
      end
      (opc == OP_AUI): begin
        legal  = 1'b1;
        use_rd = 1'b1;
        wdata  = pc_q + imm_u;
      end
      (opc == OP_IMM && f3 == 3'b000): begin
        legal  = 1'b1;
        use_rd = 1'b1;
        use_r1 = 1'b1;
        wdata  = rs1_v + imm_i;
      end
      (opc == OP_REG && f3 == 3'b000 && f7 == 7'd0): begin
        legal  = 1'b1;
        use_rd = 1'b1;
        use_r1 = 1'b1;
        use_r2 = 1'b1;
        wdata  = rs1_v + rs2_v;
      end
      (opc == OP_JAL): begin
        legal  = 1'b1;
        use_rd = 1'b1;
        jump   = 1'b1;
        wdata  = pc_q + 32'd4;
        npc    = pc_q + imm_j;
      end
      (opc == OP_JLR && f3 == 3'b000): begin
        legal  = 1'b1;
        use_rd = 1'b1;
        use_r1 = 1'b1;
        jump   = 1'b1;
        wdata  = pc_q + 32'd4;
        npc    = (rs1_v + imm_i) & ~32'd1;
      end
`ifdef MULTICYCLE_CORE_BRANCH_EN
      (opc == OP_BR && f3[2:1] == 2'b00): begin
        legal  = 1'b1;
        use_r1 = 1'b1;
        use_r2 = 1'b1;
        // f3[0] selects bne, which inverts the equality test
        if ((rs1_v == rs2_v) ^ f3[0]) begin
          jump = 1'b1;
          npc  = pc_q + imm_b;
        end
      end
`endif
      default: ;
    endcase
  end

  assign halt_now = brk | ~legal
                  | (use_rd & idx_bad(rd))
                  | (use_r1 & idx_bad(rs1))
                  | (use_r2 & idx_bad(rs2))
                  | (jump & npc[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'd0;
      halt_q      <= 1'b0;
      illegal_q   <= 1'b0;
      halt_code_q <= 32'd0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'd0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            ir_q    <= imem_rdata;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (halt_now) begin
            state_q     <= HALT;
            halt_q      <= 1'b1;
            illegal_q   <= ~brk;
            halt_code_q <= rf_q[10];
          end else begin
            pc_q    <= npc;
            state_q <= FETCH;
            if (rd != 5'd0) rf_q[rd[AW-1:0]] <= wdata;
          end
        end
        HALT: ;
        default: state_q <= HALT;
      endcase
    end
  end

  assign imem_req  = (state_q == FETCH) & ~rst;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign retire    = (state_q == EXEC) & ~halt_now;
  assign halt      = halt_q;
  assign illegal   = illegal_q;
  assign halt_code = halt_code_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: program table plus reset/wait/abort sequences.
// Branch expectations follow MULTICYCLE_CORE_BRANCH_EN.
module tb_multicycle_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [128];

  logic        req_a, ret_a, halt_a, ill_a;
  logic [31:0] addr_a, pc_a, code_a, rdata_a;
  logic        req_b, ret_b, halt_b, ill_b;
  logic [31:0] addr_b, pc_b, code_b, rdata_b;

  assign rdata_a = mem[addr_a[8:2]];
  assign rdata_b = mem[addr_b[8:2]];

  multicycle_core u_a (
    .clk(clk), .rst(rst),
    .imem_req(req_a), .imem_addr(addr_a),
    .imem_ready(ready), .imem_rdata(rdata_a),
    .pc(pc_a), .retire(ret_a), .halt(halt_a),
    .illegal(ill_a), .halt_code(code_a)
  );

  multicycle_core #(.NREGS(16)) u_b (
    .clk(clk), .rst(rst),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_ready(ready), .imem_rdata(rdata_b),
    .pc(pc_b), .retire(ret_b), .halt(halt_b),
    .illegal(ill_b), .halt_code(code_b)
  );

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] EBK = 32'h0010_0073;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string             name;
    bit                e;
    logic [7:0][31:0]  prog;
    logic              ill;
    logic [31:0]       code;
    logic [31:0]       pc;
    int                ret;
  } vec_t;

  function automatic logic [7:0][31:0] p8(
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] a2, input logic [31:0] a3,
    input logic [31:0] a4, input logic [31:0] a5,
    input logic [31:0] a6, input logic [31:0] a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic clr_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
  endtask

  task automatic go();
    rst = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic finish_chk(input string nm, input bit e,
                            input logic ill, input logic [31:0] code,
                            input logic [31:0] pce, input int ret);
    int  n = 0;
    bit  done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (e ? ret_b : ret_a) n++;
      if (e ? halt_b : halt_a) done = 1'b1;
    end
    chk({nm, ".halted"}, 32'(done), 32'd1);
    chk({nm, ".illegal"}, 32'(e ? ill_b : ill_a), 32'(ill));
    chk({nm, ".code"}, e ? code_b : code_a, code);
    chk({nm, ".pc"}, e ? pc_b : pc_a, pce);
    chk({nm, ".retires"}, n, ret);
    repeat (3) @(negedge clk);
    chk({nm, ".req_off"}, 32'(e ? req_b : req_a), 32'd0);
    chk({nm, ".sticky"}, {31'd0, e ? halt_b : halt_a}, 32'd1);
  endtask

  vec_t vq[$];

  initial begin
    vq.push_back('{"arith", 1'b0,
      p8(32'h0050_0093, 32'hFF90_0113, 32'h0020_8533, EBK, 0, 0, 0, 0),
      1'b0, 32'hFFFF_FFFE, 32'h8000_000C, 3});
    vq.push_back('{"ujump", 1'b0,
      p8(32'h1234_50B7, 32'h0000_1517, 32'h0080_02EF, 0,
         32'h0015_0533, 32'h0055_0533, EBK, 0),
      1'b0, 32'h1234_6010, 32'h8000_0018, 5});
    vq.push_back('{"jalr", 1'b0,
      p8(32'h8000_00B7, 32'h0100_8093, 32'h0050_80E7, 0, 0,
         32'h0000_8533, EBK, 0),
      1'b0, 32'h8000_000C, 32'h8000_0018, 4});
    vq.push_back('{"zero", 1'b0,
      p8(32'h0030_0513, 0, 0, 0, 0, 0, 0, 0),
      1'b1, 32'd3, 32'h8000_0004, 1});
    vq.push_back('{"sub", 1'b0,
      p8(32'h0030_0513, 32'h4020_8533, 0, 0, 0, 0, 0, 0),
      1'b1, 32'd3, 32'h8000_0004, 1});
    vq.push_back('{"jalrmis", 1'b0,
      p8(32'h0090_0513, 32'h0020_00E7, 0, 0, 0, 0, 0, 0),
      1'b1, 32'd9, 32'h8000_0004, 1});
    vq.push_back('{"jalmis", 1'b0,
      p8(32'h0090_0513, 32'h0020_006F, 0, 0, 0, 0, 0, 0),
      1'b1, 32'd9, 32'h8000_0004, 1});
    vq.push_back('{"x0", 1'b0,
      p8(32'h0050_0013, 32'h0000_0533, EBK, 0, 0, 0, 0, 0),
      1'b0, 32'd0, 32'h8000_0008, 2});
    vq.push_back('{"rv32e_ok", 1'b1,
      p8(32'h0070_0513, EBK, 0, 0, 0, 0, 0, 0),
      1'b0, 32'd7, 32'h8000_0004, 1});
    vq.push_back('{"rv32e_bad", 1'b1,
      p8(32'h0070_0513, 32'h0010_0813, 0, 0, 0, 0, 0, 0),
      1'b1, 32'd7, 32'h8000_0004, 1});
`ifdef MULTICYCLE_CORE_BRANCH_EN
    vq.push_back('{"branch", 1'b0,
      p8(32'h0010_0513, 32'h0000_1863, 32'h0080_006F, EBK,
         32'hFE00_0EE3, 0, 0, 0),
      1'b0, 32'd1, 32'h8000_000C, 4});
`else
    vq.push_back('{"branch", 1'b0,
      p8(32'h0010_0513, 32'h0000_1863, 32'h0080_006F, EBK,
         32'hFE00_0EE3, 0, 0, 0),
      1'b1, 32'd1, 32'h8000_0004, 1});
`endif

    // reset and fetch wait states
    clr_mem();
    mem[0] = 32'h0050_0513;
    mem[1] = EBK;
    rst = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    chk("rst.req", 32'(req_a), 32'd0);
    chk("rst.halt", {30'd0, halt_a, ill_a}, 32'd0);
    chk("rst.code", code_a, 32'd0);
    chk("rst.pc", pc_a, RPC);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait.req", 32'(req_a), 32'd1);
      chk("wait.addr", addr_a, RPC);
      chk("wait.retire", 32'(ret_a), 32'd0);
      chk("wait.pc", pc_a, RPC);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("exec.retire", 32'(ret_a), 32'd1);
    chk("exec.req", 32'(req_a), 32'd0);
    finish_chk("waitprog", 1'b0, 1'b0, 32'd5, 32'h8000_0004, 0);

    // program table
    foreach (vq[k]) begin
      clr_mem();
      for (int i = 0; i < 8; i++) mem[i] = vq[k].prog[i];
      go();
      finish_chk(vq[k].name, vq[k].e, vq[k].ill,
                 vq[k].code, vq[k].pc, vq[k].ret);
    end

    // jalr to 0x80000104 with bit 0 of the sum cleared
    clr_mem();
    mem[0]  = 32'h8000_00B7;
    mem[1]  = 32'h1000_8093;
    mem[2]  = 32'h0050_80E7;
    mem[65] = 32'h0000_8533;
    mem[66] = EBK;
    go();
    finish_chk("jalr100", 1'b0, 1'b0, 32'h8000_000C, 32'h8000_0108, 4);

    // async reset in the middle of an EXEC cycle
    clr_mem();
    mem[0] = 32'h0050_0513;
    mem[1] = 32'h0090_0513;
    go();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort.pc_before", pc_a, 32'h8000_0004);
    chk("abort.in_exec", 32'(ret_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort.pc", pc_a, RPC);
    chk("abort.req", 32'(req_a), 32'd0);
    chk("abort.retire", 32'(ret_a), 32'd0);
    mem[0] = EBK;
    @(negedge clk);
    rst = 1'b0;
    finish_chk("abort", 1'b0, 1'b0, 32'd0, RPC, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
